// File: rtl/ppu_vram_arb_if.sv
// Signal bundle between the PPU VRAM arbiter, its two requesters (render pipeline, CPU PPUDATA) and VRAM.
// The arbiter uses the slave modport; requesters and the VRAM model drive the master side.
interface ppu_vram_arb_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              RENDERING;
  logic              REN_REQ;
  logic [ADDR_W-1:0] REN_ADDR;
  logic              REN_GNT;
  logic [7:0]        REN_RDATA;
  logic              REN_RVALID;
  logic              CPU_REQ;
  logic              CPU_RW;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [7:0]        CPU_WDATA;
  logic              CPU_ACK;
  logic [7:0]        CPU_RDATA;
  logic [ADDR_W-1:0] APPU;
  logic [7:0]        PPUDO;
  logic              VRAM_WE;
  logic [7:0]        PPUDI;

  modport slave (
    input  RENDERING, REN_REQ, REN_ADDR, CPU_REQ, CPU_RW, CPU_ADDR, CPU_WDATA, PPUDI,
    output REN_GNT, REN_RDATA, REN_RVALID, CPU_ACK, CPU_RDATA, APPU, PPUDO, VRAM_WE
  );

  modport master (
    output RENDERING, REN_REQ, REN_ADDR, CPU_REQ, CPU_RW, CPU_ADDR, CPU_WDATA, PPUDI,
    input  REN_GNT, REN_RDATA, REN_RVALID, CPU_ACK, CPU_RDATA, APPU, PPUDO, VRAM_WE
  );
endinterface

// File: rtl/ppu_vram_arb.sv
// Single-port VRAM arbiter between PPU render fetches and CPU PPUDATA accesses.
// Define VRAM_ARB_STARVE_GUARD_EN to add the CPU starvation guard (forces a CPU slot after STARVE_MAX waits).
module ppu_vram_arb #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned ADDR_W     = 14
) (
  input logic           PPU_SLOW_CLOCK,
  input logic           RST,
  ppu_vram_arb_if.slave bus
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_REN, OWN_CPU} owner_e;

  owner_e            owner_q, owner_d;
  logic              cpuRead_q, cpuRead_d;
  logic [ADDR_W-1:0] appu_q, appu_d;
  logic [7:0]        ppudo_q, ppudo_d;
  logic              vramWe_q, vramWe_d;
  logic              renGnt_q, renGnt_d;
  logic [7:0]        renRdata_q, renRdata_d;
  logic              renRvalid_q, renRvalid_d;
  logic              cpuAck_q, cpuAck_d;
  logic [7:0]        cpuRdata_q, cpuRdata_d;
  logic              cpuElig;
  logic              starve;

  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : gBadStarveMax
    $error("ppu_vram_arb: STARVE_MAX must be 1..15");
  end

  // The CPU may not start a new access while one is issued or still acknowledging.
  assign cpuElig = bus.CPU_REQ && (owner_q != OWN_CPU) && !cpuAck_q;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  logic [3:0] waitCnt_q, waitCnt_d;

  assign starve = cpuElig && (waitCnt_q >= 4'(STARVE_MAX));

  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!bus.CPU_REQ || (owner_d == OWN_CPU)) begin
      waitCnt_d = '0;
    end else if (cpuElig) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end
  end

  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) waitCnt_q <= '0;
    else     waitCnt_q <= waitCnt_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    owner_d     = OWN_IDLE;
    cpuRead_d   = cpuRead_q;
    appu_d      = appu_q;
    ppudo_d     = ppudo_q;
    vramWe_d    = 1'b0;
    renGnt_d    = 1'b0;
    renRvalid_d = (owner_q == OWN_REN);
    renRdata_d  = (owner_q == OWN_REN) ? bus.PPUDI : renRdata_q;
    cpuAck_d    = (owner_q == OWN_CPU);
    cpuRdata_d  = ((owner_q == OWN_CPU) && cpuRead_q) ? bus.PPUDI : cpuRdata_q;

    // Visible lines favour render; vblank favours the CPU.
    if (starve) begin
      owner_d = OWN_CPU;
    end else if (bus.RENDERING) begin
      if (bus.REN_REQ)  owner_d = OWN_REN;
      else if (cpuElig) owner_d = OWN_CPU;
    end else begin
      if (cpuElig)          owner_d = OWN_CPU;
      else if (bus.REN_REQ) owner_d = OWN_REN;
    end

    case (owner_d)
      OWN_REN: begin
        appu_d   = bus.REN_ADDR;
        renGnt_d = 1'b1;
      end
      OWN_CPU: begin
        appu_d    = bus.CPU_ADDR;
        cpuRead_d = bus.CPU_RW;
        vramWe_d  = !bus.CPU_RW;
        if (!bus.CPU_RW) ppudo_d = bus.CPU_WDATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      owner_q     <= OWN_IDLE;
      cpuRead_q   <= 1'b0;
      appu_q      <= '0;
      ppudo_q     <= '0;
      vramWe_q    <= 1'b0;
      renGnt_q    <= 1'b0;
      renRdata_q  <= '0;
      renRvalid_q <= 1'b0;
      cpuAck_q    <= 1'b0;
      cpuRdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      cpuRead_q   <= cpuRead_d;
      appu_q      <= appu_d;
      ppudo_q     <= ppudo_d;
      vramWe_q    <= vramWe_d;
      renGnt_q    <= renGnt_d;
      renRdata_q  <= renRdata_d;
      renRvalid_q <= renRvalid_d;
      cpuAck_q    <= cpuAck_d;
      cpuRdata_q  <= cpuRdata_d;
    end
  end

  assign bus.APPU       = appu_q;
  assign bus.PPUDO      = ppudo_q;
  assign bus.VRAM_WE    = vramWe_q;
  assign bus.REN_GNT    = renGnt_q;
  assign bus.REN_RDATA  = renRdata_q;
  assign bus.REN_RVALID = renRvalid_q;
  assign bus.CPU_ACK    = cpuAck_q;
  assign bus.CPU_RDATA  = cpuRdata_q;

endmodule
